// File: rtl/ps2_kbd_rx_pkg.sv
// Shared PS/2 constants, the odd-parity check and the scan codes used around the keyboard path.
package ps2_kbd_rx_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic PS2_START = 1'b0;
  localparam logic PS2_STOP  = 1'b1;

  localparam logic [7:0] SC_KEY_A    = 8'h1C;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXTENDED = 8'hE0;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic par);
    return ^{d, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for scan codes; full/empty come from the occupancy count only.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop while full frees the slot the simultaneous push needs, so the push is allowed then.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head entry is shown directly; zero while empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the pads, deframes 11-bit frames and queues good scan codes.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);
  import ps2_kbd_rx_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic       clk_s1, clk_s2, clk_hist;
  logic       data_s1, data_s2;
  logic       fall;
  logic [3:0] bit_cnt;
  logic [9:0] shift;
  logic [TMO_W-1:0] idle_cnt;
  logic       timeout_hit;
  logic       last_bit;
  logic       frame_good;
  logic       push;
  logic [7:0] push_data;
  logic       fifo_full;
  logic       fifo_empty;

  // Two-flop synchronisers plus a history flop; they reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall        = clk_hist && !clk_s2;
  assign last_bit    = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
  assign timeout_hit = (bit_cnt != '0) && !fall && (idle_cnt == TMO_W'(TIMEOUT_CYCLES));

  // shift holds start, d0..d7, parity (LSB = start); the stop bit is taken live on the last edge.
  assign frame_good = (shift[0] == PS2_START) && (data_s2 == PS2_STOP) &&
                      odd_parity_ok(shift[8:1], shift[9]);

  // Deframer: shift bits in LSB first, judge the frame on the 11th edge and stage the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        if (last_bit) begin
          bit_cnt   <= '0;
          push      <= frame_good;
          push_data <= shift[8:1];
          frame_err <= !frame_good;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shift   <= {data_s2, shift[9:1]};
        end
      end else if (timeout_hit) begin
        bit_cnt   <= '0;
        shift     <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  // Idle counter only runs inside a frame; any edge or an idle bus keeps it at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (fall || bit_cnt == '0 || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Sticky overflow: a good byte arrived while full and nothing was popped to make room.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !rd_en) begin
      overflow <= 1'b1;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: drives PS/2 frames on the pads and checks against a queue-based model.
module tb_ps2_kbd_rx;
  import ps2_kbd_rx_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 500;
  localparam int H     = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [7:0] model_q[$];
  bit model_ovf;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .data      (data),
    .valid     (valid),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Tally frame_err pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  // Build a PS/2 frame from its rules: bit0 start, data LSB first, odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (bad_par) par = !par;
    return {bad_stop ? 1'b0 : 1'b1, par, b, 1'b0};
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Device-side framing: data changes while ps2_clk is high, host samples on the falling edge.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit pop_at_push);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == nbits - 1) begin
        repeat (3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (H - 4) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", data); end
    total++; if (err_pulses !== 0) begin bad++; $display("[TB] FAIL reset_frame_err pulses=%0d want=0", err_pulses); end
  endtask

  task automatic test_good_frame();
    logic [10:0] f;
    do_reset();
    f = make_frame(SC_KEY_A, 1'b0, 1'b0);
    send_bits(f, 10, 1'b0);
    ps2_data = f[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL good_early_valid got=%b want=0", valid); end
    @(negedge clk);
    total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL good_valid got=%b want=1", valid); end
    total++; if (data !== SC_KEY_A) begin bad++; $display("[TB] FAIL good_data got=%h want=%h", data, SC_KEY_A); end
    total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL good_count got=%0d want=1", count); end
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    pulse_rd();
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL good_read_valid got=%b want=0", valid); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL good_read_count got=%0d want=0", count); end
  endtask

  task automatic test_bad_frames();
    int e0;
    do_reset();
    e0 = err_pulses;
    send_bits(make_frame(SC_KEY_A, 1'b1, 1'b0), 11, 1'b0);
    total++; if (err_pulses !== e0 + 1) begin bad++; $display("[TB] FAIL parity_err pulses=%0d want=%0d", err_pulses - e0, 1); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL parity_count got=%0d want=0", count); end
    send_bits(make_frame(SC_BREAK, 1'b0, 1'b1), 11, 1'b0);
    total++; if (err_pulses !== e0 + 2) begin bad++; $display("[TB] FAIL stop_err pulses=%0d want=%0d", err_pulses - e0, 2); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL stop_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL bad_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_reset();
    for (int b = 1; b <= 9; b++) begin
      send_bits(make_frame(8'(b), 1'b0, 1'b0), 11, 1'b0);
      model_push(8'(b));
    end
    total++; if (count !== 4'(model_q.size())) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=%0d", count, model_q.size()); end
    total++; if (overflow !== model_ovf) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=%b", overflow, model_ovf); end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      total++; if (valid !== 1'b1 || data !== exp) begin bad++; $display("[TB] FAIL ovf_read valid=%b data=%h want=%h", valid, data, exp); end
      pulse_rd();
    end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_drained valid=%b want=0", valid); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] b;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_bits(make_frame(b, 1'b0, 1'b0), 11, 1'b0);
      model_push(b);
    end
    send_bits(make_frame(8'h2A, 1'b0, 1'b0), 11, 1'b1);
    void'(model_q.pop_front());
    model_q.push_back(8'h2A);
    total++; if (count !== 4'(model_q.size())) begin bad++; $display("[TB] FAIL pp_count got=%0d want=%0d", count, model_q.size()); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pp_overflow got=%b want=0", overflow); end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      total++; if (data !== exp) begin bad++; $display("[TB] FAIL pp_read got=%h want=%h", data, exp); end
      pulse_rd();
    end
  endtask

  task automatic test_timeout();
    int e0;
    do_reset();
    e0 = err_pulses;
    send_bits(make_frame(8'($urandom), 1'b0, 1'b0), 4, 1'b0);
    repeat (TMO + 50) @(negedge clk);
    total++; if (err_pulses !== e0 + 1) begin bad++; $display("[TB] FAIL tmo_err pulses=%0d want=1", err_pulses - e0); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL tmo_count got=%0d want=0", count); end
    send_bits(make_frame(8'h33, 1'b0, 1'b0), 11, 1'b0);
    total++; if (count !== 4'd1 || data !== 8'h33) begin bad++; $display("[TB] FAIL tmo_next count=%0d data=%h want 1/33", count, data); end
    total++; if (err_pulses !== e0 + 1) begin bad++; $display("[TB] FAIL tmo_next_err pulses=%0d want=1", err_pulses - e0); end
    pulse_rd();
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    do_reset();
    send_bits(make_frame(SC_EXTENDED, 1'b0, 1'b0), 5, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    e0 = err_pulses;
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_count got=%0d want=0", count); end
    send_bits(make_frame(8'h33, 1'b0, 1'b0), 11, 1'b0);
    total++; if (count !== 4'd1 || data !== 8'h33) begin bad++; $display("[TB] FAIL rstmid_next count=%0d data=%h want 1/33", count, data); end
    total++; if (err_pulses !== e0) begin bad++; $display("[TB] FAIL rstmid_err pulses=%0d want=0", err_pulses - e0); end
    pulse_rd();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] exp;
    bit corrupt;
    int e0;
    int exp_err;
    int npop;
    do_reset();
    e0 = err_pulses;
    exp_err = 0;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      corrupt = ($urandom_range(0, 3) == 0);
      send_bits(make_frame(b, corrupt, 1'b0), 11, 1'b0);
      if (corrupt) exp_err++;
      else model_push(b);
      total++; if (count !== 4'(model_q.size())) begin bad++; $display("[TB] FAIL rnd_count n=%0d got=%0d want=%0d", n, count, model_q.size()); end
      total++; if (overflow !== model_ovf) begin bad++; $display("[TB] FAIL rnd_overflow n=%0d got=%b want=%b", n, overflow, model_ovf); end
      total++; if (err_pulses - e0 !== exp_err) begin bad++; $display("[TB] FAIL rnd_err n=%0d got=%0d want=%0d", n, err_pulses - e0, exp_err); end
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (model_q.size() > 0) begin
          exp = model_q.pop_front();
          total++; if (data !== exp) begin bad++; $display("[TB] FAIL rnd_read got=%h want=%h", data, exp); end
        end
        pulse_rd();
      end
    end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      total++; if (data !== exp) begin bad++; $display("[TB] FAIL rnd_drain got=%h want=%h", data, exp); end
      pulse_rd();
    end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd_empty valid=%b want=0", valid); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frames();
    test_overflow();
    test_push_pop_full();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
